// File: rtl/armleocpu_fetch_queue_if.sv
// Signals between the fetch queue and its neighbours: instruction cache,
// execute-stage redirect and decode. master = fetch queue side.
interface armleocpu_fetch_queue_if #(
  parameter int LEVEL_W = 3
);
  logic               c_reset_done;
  logic [3:0]         c_cmd;
  logic [31:0]        c_address;
  logic [3:0]         c_response;
  logic [31:0]        c_load_data;

  logic               e2f_redirect;
  logic [31:0]        e2f_redirect_pc;
  logic               e2f_flush;

  logic               f2d_valid;
  logic               f2d_ready;
  logic [31:0]        f2d_instr;
  logic [31:0]        f2d_pc;
  logic               f2d_fault;
  logic [31:0]        f2d_cause;
  logic [LEVEL_W-1:0] level;

  modport master (
    input  c_reset_done, c_response, c_load_data,
           e2f_redirect, e2f_redirect_pc, e2f_flush, f2d_ready,
    output c_cmd, c_address,
           f2d_valid, f2d_instr, f2d_pc, f2d_fault, f2d_cause, level
  );

  modport slave (
    output c_reset_done, c_response, c_load_data,
           e2f_redirect, e2f_redirect_pc, e2f_flush, f2d_ready,
    input  c_cmd, c_address,
           f2d_valid, f2d_instr, f2d_pc, f2d_fault, f2d_cause, level
  );
endinterface

// File: rtl/armleocpu_fetch_queue.sv
// Run-ahead instruction fetch: issues cache reads into a DEPTH-entry FWFT FIFO
// feeding decode; redirects from execute flush the queue and restart fetching.
module armleocpu_fetch_queue #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_2000,
  parameter int          DEPTH        = 4,
  parameter int          LEVEL_W      = $clog2(DEPTH) + 1
) (
  input logic                     clk,
  input logic                     rst,
  armleocpu_fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [3:0]  CMD_NONE         = 4'd0;
  localparam logic [3:0]  CMD_EXECUTE      = 4'd1;
  localparam logic [3:0]  CMD_FLUSH_ALL    = 4'd4;
  localparam logic [3:0]  RESP_WAIT        = 4'd1;
  localparam logic [3:0]  RESP_DONE        = 4'd2;
  localparam logic [3:0]  RESP_ACCESSFAULT = 4'd3;
  localparam logic [3:0]  RESP_MISSALIGNED = 4'd4;
  localparam logic [3:0]  RESP_PAGEFAULT   = 4'd5;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] EXC_INSTR_MISALIGNED = 32'd0;
  localparam logic [31:0] EXC_INSTR_ACCESS     = 32'd1;
  localparam logic [31:0] EXC_INSTR_PAGE       = 32'd12;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH, S_HALT} state_t;

  function automatic logic [31:0] cause_of(input logic [3:0] resp);
    case (resp)
      RESP_MISSALIGNED: cause_of = EXC_INSTR_MISALIGNED;
      RESP_PAGEFAULT:   cause_of = EXC_INSTR_PAGE;
      default:          cause_of = EXC_INSTR_ACCESS;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               discard_q, discard_d;
  logic               flush_pend_q, flush_pend_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0] count_q, count_d, level_next;

  logic [31:0]        instr_q [DEPTH];
  logic [31:0]        epc_q   [DEPTH];
  logic               fault_q [DEPTH];
  logic [31:0]        cause_q [DEPTH];

  logic resp_done, resp_err, terminal, pop, push, issue_ok;

  always_comb begin
    resp_done  = (bus.c_response == RESP_DONE);
    resp_err   = (bus.c_response == RESP_ACCESSFAULT) ||
                 (bus.c_response == RESP_MISSALIGNED) ||
                 (bus.c_response == RESP_PAGEFAULT);
    terminal   = resp_done || resp_err;
    pop        = (count_q != '0) && bus.f2d_ready && !bus.e2f_redirect;
    push       = (state_q == S_WAIT) && terminal && !discard_q && !bus.e2f_redirect;
    // Occupancy after this cycle; a new request needs a slot left once it completes.
    level_next = count_q + LEVEL_W'(push) - LEVEL_W'(pop);
    issue_ok   = !rst && bus.c_reset_done && (bus.c_response != RESP_WAIT) &&
                 (level_next < LEVEL_W'(DEPTH));
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    flush_pend_d  = flush_pend_q;
    bus.c_cmd     = CMD_NONE;
    bus.c_address = pc_q;
    if (bus.e2f_redirect) begin
      pc_d = bus.e2f_redirect_pc;
      case (state_q)
        S_WAIT: begin
          if (!terminal) begin
            // Request still in flight: its response must be swallowed later.
            discard_d    = 1'b1;
            flush_pend_d = flush_pend_q | bus.e2f_flush;
          end else begin
            discard_d    = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = (bus.e2f_flush || flush_pend_q) ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          if (bus.c_reset_done && !resp_done) bus.c_cmd = CMD_FLUSH_ALL;
          if (resp_done) state_d = bus.e2f_flush ? S_FLUSH : S_IDLE;
        end
        default: state_d = bus.e2f_flush ? S_FLUSH : S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_ok) begin
            bus.c_cmd = CMD_EXECUTE;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (terminal) begin
            if (discard_q) begin
              discard_d = 1'b0;
              if (flush_pend_q) begin
                flush_pend_d = 1'b0;
                state_d      = S_FLUSH;
              end else if (issue_ok) begin
                bus.c_cmd = CMD_EXECUTE;
              end else begin
                state_d = S_IDLE;
              end
            end else if (resp_done) begin
              pc_d          = pc_q + 32'd4;
              bus.c_address = pc_q + 32'd4;
              if (issue_ok) bus.c_cmd = CMD_EXECUTE;
              else          state_d   = S_IDLE;
            end else begin
              state_d = S_HALT;
            end
          end
        end
        S_FLUSH: begin
          if (resp_done)              state_d   = S_IDLE;
          else if (bus.c_reset_done)  bus.c_cmd = CMD_FLUSH_ALL;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = level_next;
    if (bus.e2f_redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      discard_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      flush_pend_q <= flush_pend_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= resp_done ? bus.c_load_data : NOP;
      epc_q[wr_ptr_q]   <= pc_q;
      fault_q[wr_ptr_q] <= !resp_done;
      cause_q[wr_ptr_q] <= resp_done ? 32'd0 : cause_of(bus.c_response);
    end
  end

  // Empty queue presents the idle values so outputs are defined straight out of reset.
  always_comb begin
    bus.f2d_valid = (count_q != '0);
    bus.f2d_instr = NOP;
    bus.f2d_pc    = 32'd0;
    bus.f2d_fault = 1'b0;
    bus.f2d_cause = 32'd0;
    bus.level     = count_q;
    if (bus.f2d_valid) begin
      bus.f2d_instr = instr_q[rd_ptr_q];
      bus.f2d_pc    = epc_q[rd_ptr_q];
      bus.f2d_fault = fault_q[rd_ptr_q];
      bus.f2d_cause = cause_q[rd_ptr_q];
    end
  end
endmodule

// File: tb/tb_armleocpu_fetch_queue.sv
// Directed bench for armleocpu_fetch_queue with a behavioural cache and a
// scoreboard of the entries decode is expected to receive.
module tb_armleocpu_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int LEVEL_W = 3;
  localparam logic [3:0]  C_NONE = 4'd0, C_EXEC = 4'd1, C_FLUSH = 4'd4;
  localparam logic [3:0]  R_IDLE = 4'd0, R_WAIT = 4'd1, R_DONE = 4'd2, R_PAGE = 4'd5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] cause;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  armleocpu_fetch_queue_if #(.LEVEL_W(LEVEL_W)) bus();

  armleocpu_fetch_queue #(
    .RESET_VECTOR(32'h0000_2000),
    .DEPTH(DEPTH),
    .LEVEL_W(LEVEL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  entry_t      exp_q[$];
  logic [31:0] exec_q[$];
  int n_cmp = 0, n_fail = 0;
  int flush_cnt = 0, seen_dead = 0;
  int cache_wait = 1, flush_wait = 3;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    instr_of = (a == 32'h6000) ? 32'h0000_DEAD : {16'hC0DE, a[15:0]};
  endfunction
  function automatic logic [3:0] resp_of(input logic [31:0] a);
    resp_of = (a == 32'h3000) ? R_PAGE : R_DONE;
  endfunction
  function automatic int wait_of(input logic [31:0] a);
    wait_of = (a == 32'h6000) ? 3 : cache_wait;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic fault, input logic [31:0] cause);
    entry_t e;
    e.instr = fault ? NOP : instr_of(pc);
    e.pc    = pc;
    e.fault = fault;
    e.cause = cause;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    bus.f2d_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1);
    bus.f2d_ready = 1'b0;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] exec_at(input int i);
    exec_at = (i < exec_q.size()) ? exec_q[i] : 32'hFFFF_FFFF;
  endfunction

  // Cache model: a command seen in one cycle is answered from the next cycle.
  initial begin
    logic [3:0]  cmd_s;
    logic [31:0] addr_s, paddr;
    logic        pend, pflush;
    int          rem;
    pend = 1'b0; pflush = 1'b0; rem = 0; paddr = '0;
    bus.c_response  = R_IDLE;
    bus.c_load_data = '0;
    forever begin
      @(negedge clk);
      cmd_s  = bus.c_cmd;
      addr_s = bus.c_address;
      @(posedge clk);
      #1;
      if (rst) begin
        pend = 1'b0;
        bus.c_response = R_IDLE;
      end else begin
        if (!pend && cmd_s != C_NONE) begin
          pend   = 1'b1;
          pflush = (cmd_s == C_FLUSH);
          paddr  = addr_s;
          rem    = pflush ? flush_wait : wait_of(addr_s);
        end
        if (pend) begin
          if (rem > 0) begin
            bus.c_response = R_WAIT;
            rem--;
          end else begin
            pend = 1'b0;
            if (pflush) bus.c_response = R_DONE;
            else begin
              bus.c_response  = resp_of(paddr);
              bus.c_load_data = instr_of(paddr);
            end
          end
        end else begin
          bus.c_response = R_IDLE;
        end
      end
    end
  end

  // Decode-side scoreboard and command monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.c_cmd == C_EXEC)  exec_q.push_back(bus.c_address);
      if (bus.c_cmd == C_FLUSH) flush_cnt++;
      if (bus.f2d_valid && bus.f2d_instr == 32'h0000_DEAD) seen_dead++;
      if (bus.f2d_valid && bus.f2d_ready && !bus.e2f_redirect) begin
        check("output_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          entry_t e;
          e = exp_q.pop_front();
          check("f2d_pc",    bus.f2d_pc,           e.pc);
          check("f2d_instr", bus.f2d_instr,        e.instr);
          check("f2d_fault", 32'(bus.f2d_fault),   32'(e.fault));
          check("f2d_cause", bus.f2d_cause,        e.cause);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.c_reset_done    = 1'b1;
    bus.e2f_redirect    = 1'b0;
    bus.e2f_redirect_pc = '0;
    bus.e2f_flush       = 1'b0;
    bus.f2d_ready       = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.f2d_valid), 32'd0);
    check("rst_instr", bus.f2d_instr,      NOP);
    check("rst_pc",    bus.f2d_pc,         32'd0);
    check("rst_fault", 32'(bus.f2d_fault), 32'd0);
    check("rst_cause", bus.f2d_cause,      32'd0);
    check("rst_level", 32'(bus.level),     32'd0);
    check("rst_cmd",   32'(bus.c_cmd),     32'(C_NONE));

    // Streaming from the reset vector, one WAIT per access.
    step(2);
    expect_entry(32'h2000, 1'b0, 32'd0);
    expect_entry(32'h2004, 1'b0, 32'd0);
    expect_entry(32'h2008, 1'b0, 32'd0);
    exec_q.delete();
    rst = 1'b0;
    drain("drain_stream");
    check("first_exec_reset", exec_at(0), 32'h2000);

    // Fill to DEPTH with zero-wait cache, then a single pop.
    step(12);
    cache_wait = 0;
    exec_q.delete();
    bus.e2f_redirect = 1'b1; bus.e2f_redirect_pc = 32'h5000;
    step(1);
    bus.e2f_redirect = 1'b0;
    @(negedge clk);
    check("level_after_redir_fill", 32'(bus.level), 32'd0);
    step(15);
    check("fill_exec_count", 32'(exec_q.size()), 32'd4);
    check("fill_exec0",      exec_at(0), 32'h5000);
    check("fill_exec3",      exec_at(3), 32'h500C);
    check("fill_level",      32'(bus.level), 32'd4);
    expect_entry(32'h5000, 1'b0, 32'd0);
    bus.f2d_ready = 1'b1;
    step(1);
    bus.f2d_ready = 1'b0;
    step(8);
    check("pop_exec_count", 32'(exec_q.size()), 32'd5);
    check("pop_exec4",      exec_at(4), 32'h5010);
    check("pop_level",      32'(bus.level), 32'd4);
    check("pop_sb_empty",   32'(exp_q.size()), 32'd0);

    // Redirect while a request to 0x6000 is waiting; its 0xDEAD data is dropped.
    cache_wait = 1;
    bus.e2f_redirect = 1'b1; bus.e2f_redirect_pc = 32'h6000;
    step(1);
    bus.e2f_redirect = 1'b0;
    step(2);
    exec_q.delete();
    bus.e2f_redirect = 1'b1; bus.e2f_redirect_pc = 32'h0100;
    step(1);
    bus.e2f_redirect = 1'b0;
    @(negedge clk);
    check("level_after_redir", 32'(bus.level), 32'd0);
    expect_entry(32'h0100, 1'b0, 32'd0);
    expect_entry(32'h0104, 1'b0, 32'd0);
    drain("drain_redirect");
    check("redir_first_exec", exec_at(0), 32'h0100);
    check("dead_never_seen",  32'(seen_dead), 32'd0);

    // Page fault at 0x3000 halts fetching.
    step(10);
    exec_q.delete();
    bus.e2f_redirect = 1'b1; bus.e2f_redirect_pc = 32'h2FF8;
    step(1);
    bus.e2f_redirect = 1'b0;
    step(20);
    check("fault_level",      32'(bus.level), 32'd3);
    check("fault_exec_count", 32'(exec_q.size()), 32'd3);
    check("fault_exec2",      exec_at(2), 32'h3000);
    expect_entry(32'h2FF8, 1'b0, 32'd0);
    expect_entry(32'h2FFC, 1'b0, 32'd0);
    expect_entry(32'h3000, 1'b1, 32'd12);
    drain("drain_fault");
    step(5);
    check("halt_exec_count", 32'(exec_q.size()), 32'd3);
    check("halt_level",      32'(bus.level), 32'd0);

    // Redirect with cache flush over a full stale queue.
    bus.e2f_redirect = 1'b1; bus.e2f_redirect_pc = 32'h0700;
    step(1);
    bus.e2f_redirect = 1'b0;
    step(12);
    check("stale_level", 32'(bus.level), 32'd4);
    flush_cnt = 0;
    exec_q.delete();
    bus.e2f_redirect = 1'b1; bus.e2f_redirect_pc = 32'h0400; bus.e2f_flush = 1'b1;
    step(1);
    bus.e2f_redirect = 1'b0; bus.e2f_flush = 1'b0;
    @(negedge clk);
    check("flush_level_cleared", 32'(bus.level), 32'd0);
    step(10);
    check("flush_cycles",     32'(flush_cnt), 32'd4);
    check("flush_first_exec", exec_at(0), 32'h0400);
    expect_entry(32'h0400, 1'b0, 32'd0);
    expect_entry(32'h0404, 1'b0, 32'd0);
    drain("drain_flush");

    // Asynchronous reset while a request is outstanding.
    step(12);
    cache_wait = 3;
    expect_entry(32'h0408, 1'b0, 32'd0);
    bus.f2d_ready = 1'b1;
    step(1);
    bus.f2d_ready = 1'b0;
    step(1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.f2d_valid), 32'd0);
    check("arst_level", 32'(bus.level),     32'd0);
    check("arst_instr", bus.f2d_instr,      NOP);
    check("arst_pc",    bus.f2d_pc,         32'd0);
    check("arst_cmd",   32'(bus.c_cmd),     32'(C_NONE));
    check("arst_sb",    32'(exp_q.size()),  32'd0);
    step(2);
    cache_wait = 1;
    exec_q.delete();
    rst = 1'b0;
    step(6);
    check("arst_first_exec", exec_at(0), 32'h2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
